timer_input_capture: RTL and testbench
======================================

Name: timer_input_capture

Overview:
Input-capture companion to the compare timer: the timer drives compare events out, and this block timestamps edges coming in. It runs its own prescaled free-running counter. It synchronises an external capture_in pin and detects the selected edge(s), then pushes the counter value into a small capture FIFO. The block has the same 4-bit-address configuration/read port style as the timer register file, and raises capture/overflow interrupts.

Parameters:
COUNTER_BIT_WIDTH, 8, width of counter, capture entries and data bus; must be >= 8.
CAPTURE_DEPTH, 4, capture FIFO depth; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  block enable; low freezes counter/prescaler, ignores edges, writes and pops.
capture_in  input  1  asynchronous external signal to timestamp.
config_address  input  4  register address.
config_write_enable  input  1  register write strobe.
config_read_enable  input  1  read strobe; pops the FIFO when address = 0x3.
write_data  input  COUNTER_BIT_WIDTH  register write data.
read_data  output  COUNTER_BIT_WIDTH  combinational read of the addressed register.
capture_irq  output  1  cap_int_en & fifo_not_empty.
overflow_irq  output  1  ovf_int_en & overflow_f.

Behaviour:
- Reset (rst=1 at a clk edge):
  - CTRL = 0, PRESCALE = 0, counter = 0, prescaler count = 0.
  - FIFO empty, overflow_f = 0, sync flops = 0.
  - Both irqs 0. read_data follows the address (0 for CTRL, 0 for CAPTURE when empty).
- Register map (unlisted addresses read 0; writes to them are ignored):
  - 0x0 CTRL (R/W):
    - bit0 start.
    - bits2:1 edge_sel: 00 rising, 01 falling, 10 both, 11 none.
    - bit3 cap_int_en.
    - bit4 ovf_int_en.
    - Other bits read 0.
  - 0x1 STATUS (R): bit0 not_empty, bit1 full, bit2 overflow_f; bits 7:3 hold the FIFO occupancy, zero-extended. Writing 1 to bit2 clears overflow_f; writing 0 has no effect.
  - 0x2 COUNT (R/W): the live counter. A write loads the value at the next edge and has priority over the increment.
  - 0x3 CAPTURE (R): FIFO head, or 0 when empty. A pop needs config_read_enable=1, enable=1 and not_empty.
  - 0x4 PRESCALE (R/W): low 8 bits used.
- Writes and pops take effect only when enable=1.
- Counter and prescaler:
  - A tick occurs every PRESCALE+1 clk cycles while start & enable.
  - The counter increments on each tick and wraps from all-ones to 0.
  - When start=0, the counter and prescaler hold their values.
  - Writing PRESCALE resets the prescaler count to 0.
- Synchroniser and edge detection:
  - capture_in passes through 2 flops (s1, s2), then a history flop s3.
  - Rising = s2 & ~s3; falling = ~s2 & s3.
  - An edge on capture_in set up before clk edge N is visible in s2 after edge N+1.
  - The push happens at edge N+2 and stores the counter value held during the cycle between N+1 and N+2, i.e. the pre-increment value.
- Push rules:
  - A push is qualified by start & enable and a matching edge_sel.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow_f is set (sticky). Existing entries are never overwritten.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy is unchanged and order is preserved.
  - Overflow set and write-1-clear in the same cycle: set wins.
  - COUNT write in the same cycle as a push: the FIFO stores the old (pre-write) value.
- Changing edge_sel or start mid-stream does not affect edges already pushed.
- Reset mid-operation discards all FIFO contents and flags in the same cycle.

Test Plan:
- Reset, then read every address -> all read 0; capture_irq = overflow_irq = 0.
- CTRL=0x09 (start, rising, cap_int_en), PRESCALE=0, capture_in rises when count=5 -> CAPTURE reads 7 (two sync cycles), STATUS=0x09; capture_irq=1. A pop gives STATUS=0x00 and capture_irq=0.
- PRESCALE=3, start -> the counter advances once per 4 clks. COUNT write 0xFE, then 3 ticks -> reads 0x01 (wrap).
- edge_sel=10 (both), 5 pulses with FIFO depth 4 and no pops:
  - 4 entries held in order; the 5th and later edges are dropped.
  - STATUS=0x27 (occupancy 4, overflow, full, not_empty).
  - overflow_irq=1 only when ovf_int_en=1.
  - Write STATUS=0x04 -> overflow_f=0.
- FIFO full, with pop and new edge in the same cycle -> occupancy stays 4, overflow_f stays 0, newest entry is at the tail.
- enable=0 during an edge, a COUNT write and a pop -> no capture, counter unchanged, FIFO unchanged. Assert rst with 3 entries -> empty next cycle.

Source files
------------

// File: rtl/timer_input_capture.sv
// timer_input_capture: prescaled free-running counter that timestamps synchronised
// capture_in edges into a small FIFO, with a 4-bit-address register port and irqs.
module timer_input_capture #(
    parameter int COUNTER_BIT_WIDTH = 8,
    parameter int CAPTURE_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         capture_in,
    input  logic [3:0]                   config_address,
    input  logic                         config_write_enable,
    input  logic                         config_read_enable,
    input  logic [COUNTER_BIT_WIDTH-1:0] write_data,
    output logic [COUNTER_BIT_WIDTH-1:0] read_data,
    output logic                         capture_irq,
    output logic                         overflow_irq
);
    localparam int W  = COUNTER_BIT_WIDTH;
    localparam int AW = $clog2(CAPTURE_DEPTH);
    localparam int OW = AW + 1;

    logic [4:0]    ctrl_q, ctrl_d;
    logic [7:0]    psc_q, psc_d, pre_q, pre_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [2:0]    sync_q;
    logic [AW-1:0] wp_q, rp_q;
    logic [OW-1:0] occ_q;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  mem_q [CAPTURE_DEPTH];
    logic          we, start, tick, rise, fall, hit, ne, full, pop, push_req, push;

    assign we       = enable & config_write_enable;
    assign start    = ctrl_q[0];
    assign tick     = start & enable & (pre_q == psc_q);
    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];
    assign hit      = ctrl_q[2:1] == 2'b00 ? rise :
                      ctrl_q[2:1] == 2'b01 ? fall :
                      ctrl_q[2:1] == 2'b10 ? rise | fall : 1'b0;
    assign ne       = occ_q != '0;
    assign full     = occ_q == OW'(CAPTURE_DEPTH);
    assign pop      = enable & config_read_enable & (config_address == 4'h3) & ne;
    assign push_req = start & enable & hit;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req & (~full | pop);

    always_comb begin
        ctrl_d = (we && config_address == 4'h0) ? write_data[4:0] : ctrl_q;
        psc_d  = (we && config_address == 4'h4) ? write_data[7:0] : psc_q;
        pre_d  = (we && config_address == 4'h4) || tick ? 8'd0 :
                 (start && enable) ? pre_q + 8'd1 : pre_q;
        cnt_d  = (we && config_address == 4'h2) ? write_data :
                 tick ? cnt_q + W'(1) : cnt_q;
        ovf_d  = (push_req & ~push) |
                 (ovf_q & ~(we && config_address == 4'h1 && write_data[2]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            psc_q  <= '0;
            pre_q  <= '0;
            cnt_q  <= '0;
            sync_q <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            psc_q  <= psc_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            sync_q <= {sync_q[1:0], capture_in};
            wp_q   <= wp_q + AW'(push);
            rp_q   <= rp_q + AW'(pop);
            occ_q  <= occ_q + OW'(push) - OW'(pop);
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= cnt_q;
    end

    always_comb begin
        read_data = config_address == 4'h0 ? W'(ctrl_q) :
                    config_address == 4'h1 ? W'({occ_q, ovf_q, full, ne}) :
                    config_address == 4'h2 ? cnt_q :
                    config_address == 4'h3 ? (ne ? mem_q[rp_q] : '0) :
                    config_address == 4'h4 ? W'(psc_q) : '0;
    end

    assign capture_irq  = ctrl_q[3] & ne;
    assign overflow_irq = ctrl_q[4] & ovf_q;
endmodule

// File: tb/tb_timer_input_capture.sv
// tb_timer_input_capture: directed vectors with hand-computed expectations for
// the input-capture timer (default 8-bit counter, 4-deep FIFO).
module tb_timer_input_capture;
    logic       clk = 1'b0;
    logic       rst, enable, capture_in, config_write_enable, config_read_enable;
    logic [3:0] config_address;
    logic [7:0] write_data, read_data;
    logic       capture_irq, overflow_irq;
    int         errors = 0;
    int         checks = 0;

    timer_input_capture #(.COUNTER_BIT_WIDTH(8), .CAPTURE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .capture_in(capture_in),
        .config_address(config_address), .config_write_enable(config_write_enable),
        .config_read_enable(config_read_enable), .write_data(write_data),
        .read_data(read_data), .capture_irq(capture_irq), .overflow_irq(overflow_irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        config_address = a;
        write_data = d;
        config_write_enable = 1'b1;
        tick();
        config_write_enable = 1'b0;
    endtask

    task automatic rc(input logic [3:0] a, input logic [7:0] e, input string tag);
        config_address = a;
        #1;
        check(tag, read_data, e);
    endtask

    task automatic pop();
        config_address = 4'h3;
        config_read_enable = 1'b1;
        tick();
        config_read_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; capture_in = 1'b0;
        config_address = '0; config_write_enable = 1'b0; config_read_enable = 1'b0;
        write_data = '0;
        tick(); tick();
        rst = 1'b0;
        rc(4'h0, 8'h00, "rst_ctrl");
        rc(4'h1, 8'h00, "rst_status");
        rc(4'h2, 8'h00, "rst_count");
        rc(4'h3, 8'h00, "rst_capture");
        rc(4'h4, 8'h00, "rst_prescale");
        rc(4'hf, 8'h00, "rst_unmapped");
        check("rst_irqs", {capture_irq, overflow_irq}, 2'b00);

        // basic rising capture: edge while count=5 stores 7
        wr(4'h4, 8'h00);
        wr(4'h0, 8'h09);
        repeat (5) tick();
        rc(4'h2, 8'h05, "count_run");
        capture_in = 1'b1;
        repeat (3) tick();
        rc(4'h3, 8'h07, "cap_value");
        rc(4'h1, 8'h09, "cap_status");
        check("cap_irq_set", capture_irq, 1'b1);
        pop();
        rc(4'h1, 8'h00, "pop_status");
        check("cap_irq_clr", capture_irq, 1'b0);

        // prescale 3 and wrap
        wr(4'h0, 8'h00);
        wr(4'h2, 8'hfe);
        wr(4'h4, 8'h03);
        wr(4'h0, 8'h01);
        repeat (3) tick();
        rc(4'h2, 8'hfe, "psc_hold");
        tick();
        rc(4'h2, 8'hff, "psc_tick");
        repeat (8) tick();
        rc(4'h2, 8'h01, "psc_wrap");

        // both edges, 10 edges into a 4-deep FIFO
        wr(4'h0, 8'h00);
        capture_in = 1'b0;
        wr(4'h4, 8'h00);
        wr(4'h2, 8'h00);
        tick(); tick();
        wr(4'h0, 8'h05);
        for (int i = 0; i < 10; i++) begin
            capture_in = ~capture_in;
            tick(); tick();
        end
        tick(); tick();
        rc(4'h1, 8'h27, "ovf_status");
        check("ovf_irq_masked", overflow_irq, 1'b0);
        wr(4'h0, 8'h14);
        check("ovf_irq_en", overflow_irq, 1'b1);
        wr(4'h1, 8'h04);
        rc(4'h1, 8'h23, "ovf_cleared");
        check("ovf_irq_clr", overflow_irq, 1'b0);

        // full FIFO: pop and push land on the same edge
        wr(4'h2, 8'h40);
        wr(4'h0, 8'h15);
        capture_in = ~capture_in;
        tick(); tick();
        rc(4'h3, 8'h02, "head_before");
        pop();
        rc(4'h1, 8'h23, "pushpop_status");
        check("pushpop_ovf_irq", overflow_irq, 1'b0);
        wr(4'h0, 8'h14);
        rc(4'h3, 8'h04, "fifo_0"); pop();
        rc(4'h3, 8'h06, "fifo_1"); pop();
        rc(4'h3, 8'h08, "fifo_2"); pop();
        rc(4'h3, 8'h42, "fifo_tail"); pop();
        rc(4'h1, 8'h00, "drained");

        // enable low freezes everything
        wr(4'h2, 8'h80);
        wr(4'h0, 8'h05);
        for (int i = 0; i < 3; i++) begin
            capture_in = ~capture_in;
            tick(); tick();
        end
        tick(); tick();
        rc(4'h1, 8'h19, "three_status");
        rc(4'h2, 8'h88, "three_count");
        enable = 1'b0;
        capture_in = ~capture_in;
        wr(4'h2, 8'h11);
        pop();
        tick(); tick(); tick();
        rc(4'h2, 8'h88, "dis_count");
        rc(4'h1, 8'h19, "dis_status");
        rc(4'h3, 8'h82, "dis_head");

        enable = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rc(4'h1, 8'h00, "mid_rst_status");
        rc(4'h0, 8'h00, "mid_rst_ctrl");
        rc(4'h2, 8'h00, "mid_rst_count");
        rc(4'h3, 8'h00, "mid_rst_capture");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
